// File: rtl/cpc_rom_pkg.sv
// Shared types and constants for the CPC ROM board controller:
// FSM encodings, unlock bytes and status bit positions.
package cpc_rom_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WPULSE,
      BUSY
   } wr_state_e;

   typedef enum logic [1:0] {
      LK0,
      LK1,
      LK2
   } lk_state_e;

   localparam logic [7:0] UNLOCK_B0 = 8'h55;
   localparam logic [7:0] UNLOCK_B1 = 8'hAA;
   localparam logic [7:0] UNLOCK_B2 = 8'h01;

   localparam int ST_WREN = 0;
   localparam int ST_BUSY = 1;
   localparam int ST_OVR  = 2;

endpackage

// File: rtl/cpc_bus_edge.sv
// Registers a Z80 bus strobe and yields one-cycle rise/fall
// pulses from the registered copy, one event per bus cycle.
module cpc_bus_edge (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic strobe_i,
   output logic rise_o,
   output logic fall_o
);

   logic strb_q;
   logic strb_dly_q;

   // sample the strobe, then keep one cycle of history
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         strb_q     <= 1'b0;
         strb_dly_q <= 1'b0;
      end else begin
         strb_q     <= strobe_i;
         strb_dly_q <= strb_q;
      end
   end

   assign rise_o = strb_q & ~strb_dly_q;
   assign fall_o = ~strb_q & strb_dly_q;

endmodule

// File: rtl/cpc_rom_ctrl.sv
// CPC eight-slot ROM board controller: romsel latch, slot decode,
// unlock handshake and timed 28C256 byte-write sequencer.
module cpc_rom_ctrl
   import cpc_rom_pkg::*;
#(
   parameter logic [7:0] BANK_BASE = 8'd0,
   parameter logic [7:0] SLOT_EN   = 8'hFF,
   parameter logic [7:0] CFG_PORT  = 8'hDC,
   parameter int         WE_CYCLES = 2,
   parameter int         WC_CYCLES = 40000
) (
   input  logic       CLK,
   input  logic       RESET_B,
   input  logic [7:0] A_HI,
   input  logic [7:0] D_IN,
   output logic [7:0] D_OUT,
   output logic       D_OE,
   input  logic       IOREQ_B,
   input  logic       MREQ_B,
   input  logic       RD_B,
   input  logic       WR_B,
   input  logic       M1_B,
   input  logic       ROMEN_B,
   output logic       ROMDIS,
   output logic [3:0] rom_cs_b,
   output logic       rom_a14,
   output logic       rom_oe_b,
   output logic       rom_we_b
);

   localparam int CNT_MAX =
      (WE_CYCLES > WC_CYCLES) ? WE_CYCLES : WC_CYCLES;
   localparam int CW = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] WE_LOAD = CW'(WE_CYCLES - 1);
   localparam logic [CW-1:0] WC_LOAD = CW'(WC_CYCLES - 1);

   logic io_wr, io_rd, mem_wr;
   logic io_wr_rise, io_rd_rise, io_rd_fall, mem_wr_rise;
   logic io_wr_fall_unused, mem_wr_fall_unused;

   logic [7:0]    romsel_q;
   logic          wr_en_q;
   logic          ovr_q, ovr_d;
   logic          cfg_rd_q;
   logic          rom_we_b_q;
   logic [CW-1:0] cnt_q;
   lk_state_e     lk_q;
   wr_state_e     wst_q;

   logic cfg_sel, cfg_wr, sel_wr;
   logic hit, upper, busy, wr_hit, ovr_set, ovr_clr;

   assign io_wr  = ~IOREQ_B & ~WR_B;
   assign io_rd  = ~IOREQ_B & ~RD_B;
   assign mem_wr = ~MREQ_B & ~WR_B & M1_B;

   cpc_bus_edge u_io_wr (
      .clk_i   (CLK),
      .rst_ni  (RESET_B),
      .strobe_i(io_wr),
      .rise_o  (io_wr_rise),
      .fall_o  (io_wr_fall_unused)
   );

   cpc_bus_edge u_io_rd (
      .clk_i   (CLK),
      .rst_ni  (RESET_B),
      .strobe_i(io_rd),
      .rise_o  (io_rd_rise),
      .fall_o  (io_rd_fall)
   );

   cpc_bus_edge u_mem_wr (
      .clk_i   (CLK),
      .rst_ni  (RESET_B),
      .strobe_i(mem_wr),
      .rise_o  (mem_wr_rise),
      .fall_o  (mem_wr_fall_unused)
   );

   assign cfg_sel = (A_HI == CFG_PORT);
   assign cfg_wr  = io_wr_rise & cfg_sel;
   assign sel_wr  = io_wr_rise & ~A_HI[5] & ~cfg_sel;

   assign hit   = (romsel_q[7:3] == BANK_BASE[7:3])
                & SLOT_EN[romsel_q[2:0]];
   assign upper = ~ROMEN_B & A_HI[6];
   assign busy  = (wst_q != IDLE);

   assign wr_hit = mem_wr_rise & (A_HI[7:6] == 2'b11)
                 & wr_en_q & hit;

   assign ROMDIS   = hit & upper;
   assign rom_a14  = romsel_q[0];
   assign rom_oe_b = ROMEN_B;
   assign rom_we_b = rom_we_b_q;

   // one chip select low for the selected device pair
   always_comb begin
      rom_cs_b = 4'hF;
      if ((hit & upper) | (wst_q == WPULSE))
         rom_cs_b[romsel_q[2:1]] = 1'b0;
   end

   // ROM-select latch written through the &DFxx port
   always_ff @(posedge CLK or negedge RESET_B) begin
      if (!RESET_B) romsel_q <= 8'h00;
      else if (sel_wr) romsel_q <= D_IN;
   end

   // unlock handshake: 55, AA, 01 on the config port sets wr_en
   always_ff @(posedge CLK or negedge RESET_B) begin
      if (!RESET_B) begin
         lk_q    <= LK0;
         wr_en_q <= 1'b0;
      end else if (cfg_wr) begin
         if (lk_q == LK2 && D_IN == UNLOCK_B2) wr_en_q <= 1'b1;
         else if (!D_IN[0]) wr_en_q <= 1'b0;
         unique case (lk_q)
            LK0:     lk_q <= (D_IN == UNLOCK_B0) ? LK1 : LK0;
            LK1:     lk_q <= (D_IN == UNLOCK_B1) ? LK2 : LK0;
            default: lk_q <= LK0;
         endcase
      end
   end

   // write sequencer: WE pulse, then fixed write-cycle busy time
   always_ff @(posedge CLK or negedge RESET_B) begin
      if (!RESET_B) begin
         wst_q      <= IDLE;
         rom_we_b_q <= 1'b1;
         cnt_q      <= '0;
      end else begin
         unique case (wst_q)
            IDLE: if (wr_hit) begin
               wst_q      <= WPULSE;
               rom_we_b_q <= 1'b0;
               cnt_q      <= WE_LOAD;
            end
            WPULSE: if (cnt_q == '0) begin
               wst_q      <= BUSY;
               rom_we_b_q <= 1'b1;
               cnt_q      <= WC_LOAD;
            end else begin
               cnt_q <= cnt_q - CW'(1);
            end
            BUSY: if (cnt_q == '0) wst_q <= IDLE;
                  else cnt_q <= cnt_q - CW'(1);
            default: wst_q <= IDLE;
         endcase
      end
   end

   // overrun is sticky until a status read ends; set beats clear
   assign ovr_set = wr_hit & busy;
   assign ovr_clr = io_rd_fall & cfg_rd_q;

   always_comb begin
      ovr_d = ovr_q;
      if (ovr_clr) ovr_d = 1'b0;
      if (ovr_set) ovr_d = 1'b1;
   end

   // overrun flag, plus which port the current IO read targeted
   always_ff @(posedge CLK or negedge RESET_B) begin
      if (!RESET_B) begin
         ovr_q    <= 1'b0;
         cfg_rd_q <= 1'b0;
      end else begin
         ovr_q <= ovr_d;
         if (io_rd_rise) cfg_rd_q <= cfg_sel;
      end
   end

   assign D_OE  = io_rd & cfg_sel;
   assign D_OUT = {5'b0, ovr_q, busy, wr_en_q};

endmodule

// File: tb/tb_cpc_rom_ctrl.sv
// Scoreboard bench for cpc_rom_ctrl: three board configurations
// share one bus and are checked against a behavioural model.
module tb_cpc_rom_ctrl;

   localparam int         WE  = 3;
   localparam int         WC  = 60;
   localparam logic [7:0] CFG = 8'hDC;

   logic clk = 1'b0;
   logic reset_b = 1'b0;
   logic [7:0] a_hi = 8'h00;
   logic [7:0] d_in = 8'h00;
   logic ioreq_b = 1'b1, mreq_b = 1'b1, rd_b = 1'b1;
   logic wr_b = 1'b1, m1_b = 1'b1, romen_b = 1'b1;

   logic [7:0] dout0, dout8, doutf;
   logic doe0, doe8, doef;
   logic rdis0, rdis8, rdisf;
   logic [3:0] cs0, cs8, csf;
   logic a140, a148, a14f;
   logic oe0, oe8, oef;
   logic we0, we8, wef;

   always #5 clk = ~clk;

   cpc_rom_ctrl #(.BANK_BASE(8'd0), .SLOT_EN(8'hFF), .CFG_PORT(CFG),
      .WE_CYCLES(WE), .WC_CYCLES(WC)) u0 (
      .CLK(clk), .RESET_B(reset_b), .A_HI(a_hi), .D_IN(d_in),
      .D_OUT(dout0), .D_OE(doe0), .IOREQ_B(ioreq_b),
      .MREQ_B(mreq_b), .RD_B(rd_b), .WR_B(wr_b), .M1_B(m1_b),
      .ROMEN_B(romen_b), .ROMDIS(rdis0), .rom_cs_b(cs0),
      .rom_a14(a140), .rom_oe_b(oe0), .rom_we_b(we0));

   cpc_rom_ctrl #(.BANK_BASE(8'd8), .SLOT_EN(8'hFF), .CFG_PORT(CFG),
      .WE_CYCLES(WE), .WC_CYCLES(WC)) u8 (
      .CLK(clk), .RESET_B(reset_b), .A_HI(a_hi), .D_IN(d_in),
      .D_OUT(dout8), .D_OE(doe8), .IOREQ_B(ioreq_b),
      .MREQ_B(mreq_b), .RD_B(rd_b), .WR_B(wr_b), .M1_B(m1_b),
      .ROMEN_B(romen_b), .ROMDIS(rdis8), .rom_cs_b(cs8),
      .rom_a14(a148), .rom_oe_b(oe8), .rom_we_b(we8));

   cpc_rom_ctrl #(.BANK_BASE(8'd0), .SLOT_EN(8'hFE), .CFG_PORT(CFG),
      .WE_CYCLES(WE), .WC_CYCLES(WC)) uf (
      .CLK(clk), .RESET_B(reset_b), .A_HI(a_hi), .D_IN(d_in),
      .D_OUT(doutf), .D_OE(doef), .IOREQ_B(ioreq_b),
      .MREQ_B(mreq_b), .RD_B(rd_b), .WR_B(wr_b), .M1_B(m1_b),
      .ROMEN_B(romen_b), .ROMDIS(rdisf), .rom_cs_b(csf),
      .rom_a14(a14f), .rom_oe_b(oef), .rom_we_b(wef));

   typedef struct {
      string      nm;
      logic [7:0] v;
   } st_t;

   typedef struct {
      string      nm;
      logic [6:0] e0;
      logic [6:0] e8;
      logic [6:0] ef;
   } dec_t;

   st_t  stq[$];
   dec_t dq[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   int rs_m = 0;
   bit wren_m = 0;
   bit ovr_m = 0;
   int lk_m = 0;
   int ws = -1000;

   always @(posedge clk) cyc++;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // reference model
   function automatic bit busy_at(int c);
      return (c >= ws + 2) && (c < ws + 2 + WE + WC);
   endfunction

   function automatic logic [7:0] st_exp(int c);
      return {5'b0, ovr_m, busy_at(c), wren_m};
   endfunction

   // {ROMDIS, cs_b[3:0], a14, oe_b} for one board configuration
   function automatic logic [6:0] dec_exp(int rs, int bank,
         int slot_en, bit up, bit wp);
      bit hit;
      logic [3:0] cs;
      hit = (rs / 8 == bank / 8) && (((slot_en >> (rs % 8)) & 1) == 1);
      cs = 4'hF;
      if ((hit && up) || wp) cs[(rs % 8) / 2] = 1'b0;
      return {hit && up, cs, (rs % 2) == 1, 1'b0};
   endfunction

   task automatic unlock_model(logic [7:0] d);
      if (lk_m == 2 && d == 8'h01) wren_m = 1;
      else if (!d[0]) wren_m = 0;
      if (lk_m == 0 && d == 8'h55) lk_m = 1;
      else if (lk_m == 1 && d == 8'hAA) lk_m = 2;
      else lk_m = 0;
   endtask

   task automatic mem_model(logic [7:0] ahi, bit m1, int c0);
      bit q;
      q = m1 && ahi[7:6] == 2'b11 && wren_m && (rs_m / 8 == 0);
      if (q) begin
         if (busy_at(c0 + 1)) ovr_m = 1;
         else ws = c0;
      end
   endtask

   task automatic reset_model();
      rs_m = 0; wren_m = 0; ovr_m = 0; lk_m = 0; ws = -1000;
   endtask

   // bus cycles
   task automatic io_write(logic [7:0] ahi, logic [7:0] d);
      a_hi = ahi; d_in = d; ioreq_b = 0; wr_b = 0;
      repeat (3) tick();
      ioreq_b = 1; wr_b = 1;
      repeat (2) tick();
      if (ahi == CFG) unlock_model(d);
      else if (!ahi[5]) rs_m = d;
   endtask

   task automatic st_read(string nm);
      st_t e;
      e.nm = nm;
      e.v = st_exp(cyc);
      stq.push_back(e);
      a_hi = CFG; ioreq_b = 0; rd_b = 0;
      repeat (3) tick();
      ioreq_b = 1; rd_b = 1;
      repeat (3) tick();
      ovr_m = 0;
   endtask

   task automatic mem_write(logic [7:0] ahi, bit m1);
      mem_model(ahi, m1, cyc);
      a_hi = ahi; d_in = 8'h5A; mreq_b = 0; wr_b = 0; m1_b = m1;
      repeat (3) tick();
      mreq_b = 1; wr_b = 1; m1_b = 1;
      tick();
   endtask

   task automatic rom_read(logic [7:0] ahi, string nm);
      dec_t e;
      e.nm = nm;
      e.e0 = dec_exp(rs_m, 0, 8'hFF, ahi[6], 0);
      e.e8 = dec_exp(rs_m, 8, 8'hFF, ahi[6], 0);
      e.ef = dec_exp(rs_m, 0, 8'hFE, ahi[6], 0);
      dq.push_back(e);
      a_hi = ahi; mreq_b = 0; rd_b = 0; romen_b = 0;
      repeat (2) tick();
      romen_b = 1; mreq_b = 1; rd_b = 1;
      tick();
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy_at(cyc) && n < 1000) begin
         tick();
         n++;
      end
      tick();
   endtask

   task automatic unlock();
      io_write(CFG, 8'h00);
      io_write(CFG, 8'h55);
      io_write(CFG, 8'hAA);
      io_write(CFG, 8'h01);
   endtask

   // monitor: compare whenever the DUT presents status or ROM data
   logic oe_prev = 1'b0;
   logic romen_prev = 1'b1;

   always @(negedge clk) begin
      if (doe0 && !oe_prev) begin
         if (stq.size() == 0) begin
            chk("status_unexpected", 1, 0);
         end else begin
            st_t e;
            e = stq.pop_front();
            chk({"status_", e.nm}, dout0, e.v);
         end
      end
      if (!romen_b && romen_prev) begin
         if (dq.size() == 0) begin
            chk("decode_unexpected", 1, 0);
         end else begin
            dec_t e;
            e = dq.pop_front();
            chk({"dec0_", e.nm}, {rdis0, cs0, a140, oe0}, e.e0);
            chk({"dec8_", e.nm}, {rdis8, cs8, a148, oe8}, e.e8);
            chk({"decf_", e.nm}, {rdisf, csf, a14f, oef}, e.ef);
         end
      end
      oe_prev    <= doe0;
      romen_prev <= romen_b;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual timeout required finish");
      $fatal(1);
   end

   initial begin
      int c0, cc, nwe, ncs, nb, n;
      logic [7:0] ahi, d;
      logic [3:0] cs_wp;

      repeat (3) tick();
      chk("rst_we_b", we0, 1);
      chk("rst_d_oe", doe0, 0);
      chk("rst_cs_b", cs0, 4'hF);
      reset_b = 1;
      tick();
      st_read("reset");
      rom_read(8'hC0, "reset");

      io_write(8'hDF, 8'h05);
      rom_read(8'hC0, "sel05_c0");
      rom_read(8'h40, "sel05_40");
      rom_read(8'h80, "sel05_80");
      io_write(8'hDF, 8'h0B);
      rom_read(8'hC0, "sel0b");
      io_write(8'hDF, 8'h00);
      rom_read(8'hC0, "sel00");
      io_write(8'hDF, 8'h01);
      rom_read(8'hC0, "sel01");

      for (int i = 0; i < 16; i++) begin
         ahi = 8'($urandom) & 8'hDF;
         if (ahi == CFG) ahi = 8'hDF;
         d = (i % 4 == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
         io_write(ahi, d);
         rom_read(8'($urandom), "rand_sel");
      end

      unlock();
      st_read("unlock");
      io_write(CFG, 8'h00);
      io_write(CFG, 8'h55);
      io_write(CFG, 8'h12);
      io_write(CFG, 8'hAA);
      io_write(CFG, 8'h01);
      st_read("bad_seq");

      for (int i = 0; i < 24; i++) begin
         n = int'($urandom_range(0, 3));
         d = (n == 0) ? 8'h55 : (n == 1) ? 8'hAA :
             (n == 2) ? 8'h01 : 8'($urandom);
         io_write(CFG, d);
         if (i % 4 == 3) st_read("rand_unlock");
      end
      rom_read(8'hC0, "cfg_no_sel");

      // timed write: WE pulse width, chip select, busy duration
      unlock();
      io_write(8'hDF, 8'h02);
      c0 = cyc;
      mem_model(8'hC1, 1, c0);
      cs_wp = 4'(dec_exp(rs_m, 0, 8'hFF, 0, 1) >> 2);
      a_hi = 8'hC1; mreq_b = 0; wr_b = 0; m1_b = 1;
      nwe = 0;
      ncs = 0;
      repeat (WE + 6) begin
         tick();
         if (!we0) nwe++;
         if (cs0 == cs_wp) ncs++;
      end
      mreq_b = 1; wr_b = 1;
      chk("we_low_cycles", nwe, WE);
      chk("cs_low_cycles", ncs, WE);
      cc = cyc;
      st_read_hold: begin
         st_t e;
         e.nm = "busy_first";
         e.v = st_exp(cc);
         stq.push_back(e);
      end
      a_hi = CFG; ioreq_b = 0; rd_b = 0;
      nb = 0;
      n = 0;
      while (dout0[1] && n < 500) begin
         nb++;
         n++;
         tick();
      end
      chk("busy_cycles", nb, ws + 2 + WE + WC - cc);
      chk("after_busy", dout0, 8'h01);
      ioreq_b = 1; rd_b = 1;
      repeat (3) tick();
      st_read("idle_after");

      // overrun while busy
      mem_write(8'hC0, 1);
      mem_write(8'hC0, 1);
      st_read("ovr_set");
      st_read("ovr_cleared");
      io_write(CFG, 8'h00);
      st_read("wren_clr_busy");
      wait_idle();
      st_read("wren_clr_done");
      mem_write(8'hC0, 1);
      st_read("locked_write");

      // non-qualifying writes
      unlock();
      mem_write(8'h80, 1);
      st_read("low_addr_write");
      mem_write(8'hC0, 0);
      st_read("m1_write");
      io_write(8'hDF, 8'h09);
      mem_write(8'hC0, 1);
      st_read("nohit_write");

      // romsel changed in the same cycle a write starts
      io_write(8'hDF, 8'h02);
      c0 = cyc;
      mem_model(8'hC0, 1, c0);
      cs_wp = 4'(dec_exp(6, 0, 8'hFF, 0, 1) >> 2);
      a_hi = 8'hC0; d_in = 8'h06;
      ioreq_b = 0; mreq_b = 0; wr_b = 0; m1_b = 1;
      repeat (2) tick();
      chk("wp_we_low", we0, 0);
      chk("wp_cs_new_sel", cs0, cs_wp);
      rs_m = 6;
      tick();
      ioreq_b = 1; mreq_b = 1; wr_b = 1;
      tick();
      wait_idle();
      st_read("wp_done");

      // reset in the middle of the write pulse
      io_write(8'hDF, 8'h02);
      c0 = cyc;
      mem_model(8'hC0, 1, c0);
      a_hi = 8'hC0; mreq_b = 0; wr_b = 0; m1_b = 1;
      n = 0;
      while (we0 !== 1'b0 && n < 8) begin
         tick();
         n++;
      end
      chk("midrst_we_low", we0, 0);
      reset_b = 0;
      #1;
      chk("midrst_we_async", we0, 1);
      chk("midrst_cs_async", cs0, 4'hF);
      mreq_b = 1; wr_b = 1;
      repeat (2) tick();
      reset_b = 1;
      reset_model();
      tick();
      st_read("midrst_status");
      rom_read(8'hC0, "midrst_dec");

      repeat (3) tick();
      chk("stq_empty", stq.size(), 0);
      chk("dq_empty", dq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
